// File: rtl/avst_chadap_pkg.sv
// -----------------------------------------------------------------------------
// avst_chadap_pkg
// Shared types and constants for the Avalon-ST channel adapter and its skid
// buffer.
//   chadap_state_e : packet-filter FSM states (IDLE, FWD, DROP)
//   SKID_DEPTH     : number of entries held by avst_skid_buf
// The beat struct depends on module parameters, so each user declares it
// locally with the widths it needs.
// -----------------------------------------------------------------------------
package avst_chadap_pkg;

    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } chadap_state_e;

endpackage

// File: rtl/avst_skid_buf.sv
// -----------------------------------------------------------------------------
// avst_skid_buf
// Two-entry buffer with a registered ready. Upstream ready depends only on the
// buffer occupancy, so there is no combinational path from i_ready to o_ready.
// Entry r_e0 is always the head; outputs come straight from registers.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_valid, i_data   upstream beat (push = i_valid & o_ready)
//   o_ready           registered "not full"
//   o_valid, o_data   head of buffer (pop = o_valid & i_ready)
//   i_ready           downstream ready
// -----------------------------------------------------------------------------
module avst_skid_buf
    import avst_chadap_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic [W-1:0] r_e0;
    logic [W-1:0] r_e1;
    logic [1:0]   r_count;
    logic         r_ready;
    logic [1:0]   w_count_nxt;
    logic         w_push;
    logic         w_pop;

    assign w_push  = i_valid & r_ready;
    assign w_pop   = (r_count != 2'd0) & i_ready;
    assign o_ready = r_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_e0;

    always_comb begin
        w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_count <= 2'd0;
            r_ready <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt < 2'(SKID_DEPTH));
            // Head takes the incoming beat when it would otherwise be empty;
            // with two entries a pop shifts the tail forward. A push while
            // full cannot happen because r_ready is low then.
            if (w_push && (w_pop ? (r_count == 2'd1) : (r_count == 2'd0)))
                r_e0 <= i_data;
            else if (w_pop && (r_count == 2'd2))
                r_e0 <= r_e1;
            if (w_push && !w_pop && (r_count == 2'd1))
                r_e1 <= i_data;
        end
    end

endmodule

// File: rtl/avst_channel_adapter_pipe.sv
// -----------------------------------------------------------------------------
// avst_channel_adapter_pipe
// Registered Avalon-ST channel adapter: rebases the input channel by CH_BASE,
// narrows it to OUT_CH_W bits and discards beats (PKT_MODE=0) or whole packets
// (PKT_MODE=1, decision taken at SOP) whose channel is out of range. Kept
// beats pass through a 2-entry skid buffer; discarded beats are still accepted
// and raise drop_pulse for one cycle.
// Optional feature: define AVST_CHADAP_DROP_CNT_EN to add drop_count (32-bit
// saturating count of discarded beats) and drop_count_clr (sync clear, wins
// over a simultaneous increment).
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   in_ready/in_valid/in_data/in_channel/in_startofpacket/in_endofpacket
//   out_ready/out_valid/out_data/out_channel/out_startofpacket/out_endofpacket
//   drop_pulse                            one pulse per discarded beat
// -----------------------------------------------------------------------------
module avst_channel_adapter_pipe
    import avst_chadap_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int IN_CH_W     = 8,
    parameter int OUT_CH_W    = 2,
    parameter int CH_BASE     = 0,
    parameter int MAX_CHANNEL = 3,
    parameter int PKT_MODE    = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                in_ready,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [IN_CH_W-1:0]  in_channel,
    input  logic                in_startofpacket,
    input  logic                in_endofpacket,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [OUT_CH_W-1:0] out_channel,
    output logic                out_startofpacket,
    output logic                out_endofpacket,
`ifdef AVST_CHADAP_DROP_CNT_EN
    input  logic                drop_count_clr,
    output logic [31:0]         drop_count,
`endif
    output logic                drop_pulse
);

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [OUT_CH_W-1:0] channel;
        logic                sop;
        logic                eop;
    } beat_t;

    localparam int              BEAT_W  = $bits(beat_t);
    localparam logic [IN_CH_W:0] LP_BASE = (IN_CH_W+1)'(CH_BASE);
    localparam logic [IN_CH_W:0] LP_MAX  = (IN_CH_W+1)'(MAX_CHANNEL);

    chadap_state_e       r_state;
    chadap_state_e       w_state_nxt;
    logic [OUT_CH_W-1:0] r_pkt_ch;
    logic                r_drop;
    logic [IN_CH_W:0]    w_ch_ext;
    logic [IN_CH_W:0]    w_rebased;
    logic                w_ok;
    logic                w_accept;
    logic                w_fwd;
    logic [OUT_CH_W-1:0] w_out_ch;
    beat_t               w_in_beat;
    beat_t               w_out_beat;
    logic                w_in_ready;

    // One extra bit so a channel below CH_BASE cannot wrap into range.
    assign w_ch_ext  = {1'b0, in_channel};
    assign w_rebased = w_ch_ext - LP_BASE;
    assign w_ok      = (w_ch_ext >= LP_BASE) && (w_rebased <= LP_MAX);
    assign w_accept  = in_valid & w_in_ready;

    always_comb begin
        w_fwd       = 1'b0;
        w_out_ch    = w_rebased[OUT_CH_W-1:0];
        w_state_nxt = r_state;
        if (PKT_MODE == 0) begin
            w_fwd = w_ok;
        end else begin
            if (in_startofpacket) begin
                // A SOP always starts a fresh decision, even mid-packet.
                w_fwd = w_ok;
            end else if (r_state == FWD) begin
                w_fwd    = 1'b1;
                w_out_ch = r_pkt_ch;
            end
            if (w_accept) begin
                if (in_startofpacket)
                    w_state_nxt = in_endofpacket ? IDLE : (w_ok ? FWD : DROP);
                else if (in_endofpacket)
                    w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_pkt_ch <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_accept & ~w_fwd;
            if (w_accept && in_startofpacket)
                r_pkt_ch <= w_rebased[OUT_CH_W-1:0];
        end
    end

`ifdef AVST_CHADAP_DROP_CNT_EN
    logic [31:0] r_drop_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_drop_cnt <= 32'd0;
        else if (drop_count_clr)
            r_drop_cnt <= 32'd0;
        else if (w_accept && !w_fwd && (r_drop_cnt != 32'hFFFF_FFFF))
            r_drop_cnt <= r_drop_cnt + 32'd1;
    end

    assign drop_count = r_drop_cnt;
`endif

    assign w_in_beat.data    = in_data;
    assign w_in_beat.channel = w_out_ch;
    assign w_in_beat.sop     = in_startofpacket;
    assign w_in_beat.eop     = in_endofpacket;

    avst_skid_buf #(
        .W (BEAT_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_valid (in_valid & w_fwd),
        .o_ready (w_in_ready),
        .i_data  (w_in_beat),
        .o_valid (out_valid),
        .o_data  (w_out_beat),
        .i_ready (out_ready)
    );

    assign in_ready          = w_in_ready;
    assign out_data          = w_out_beat.data;
    assign out_channel       = w_out_beat.channel;
    assign out_startofpacket = w_out_beat.sop;
    assign out_endofpacket   = w_out_beat.eop;
    assign drop_pulse        = r_drop;

endmodule

// File: tb/tb_avst_channel_adapter_pipe.sv
module tb_avst_channel_adapter_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    // instance A: default parameters (CH_BASE=0, MAX_CHANNEL=3, PKT_MODE=1)
    logic       in_ready, in_valid, in_sop, in_eop;
    logic [7:0] in_data, in_channel;
    logic       out_ready, out_valid, out_sop, out_eop, drop_pulse;
    logic [7:0] out_data;
    logic [1:0] out_channel;
    // instance B: CH_BASE=4, MAX_CHANNEL=3, PKT_MODE=0
    logic       b_in_ready, b_in_valid, b_in_sop, b_in_eop;
    logic [7:0] b_in_data, b_in_channel;
    logic       b_out_ready, b_out_valid, b_out_sop, b_out_eop, b_drop_pulse;
    logic [7:0] b_out_data;
    logic [1:0] b_out_channel;
`ifdef AVST_CHADAP_DROP_CNT_EN
    logic        drop_count_clr, b_drop_count_clr;
    logic [31:0] drop_count, b_drop_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ch;
        logic       sop;
        logic       eop;
    } obs_t;
    obs_t q[$];
    int   n_drop = 0;

    always #5 clk = ~clk;

    avst_channel_adapter_pipe u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data), .in_channel(in_channel),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_channel(out_channel),
        .out_startofpacket(out_sop), .out_endofpacket(out_eop),
`ifdef AVST_CHADAP_DROP_CNT_EN
        .drop_count_clr(drop_count_clr), .drop_count(drop_count),
`endif
        .drop_pulse(drop_pulse)
    );

    avst_channel_adapter_pipe #(
        .DATA_W(8), .IN_CH_W(8), .OUT_CH_W(2), .CH_BASE(4), .MAX_CHANNEL(3), .PKT_MODE(0)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .in_ready(b_in_ready), .in_valid(b_in_valid), .in_data(b_in_data), .in_channel(b_in_channel),
        .in_startofpacket(b_in_sop), .in_endofpacket(b_in_eop),
        .out_ready(b_out_ready), .out_valid(b_out_valid), .out_data(b_out_data), .out_channel(b_out_channel),
        .out_startofpacket(b_out_sop), .out_endofpacket(b_out_eop),
`ifdef AVST_CHADAP_DROP_CNT_EN
        .drop_count_clr(b_drop_count_clr), .drop_count(b_drop_count),
`endif
        .drop_pulse(b_drop_pulse)
    );

    // Record every transfer and discarded beat of instance A.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) q.push_back({out_data, out_channel, out_sop, out_eop});
            if (drop_pulse) n_drop++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Present one beat to instance A and hold it until accepted.
    task automatic send(input logic [7:0] d, input logic [7:0] ch, input logic sop, input logic eop);
        logic acc;
        in_valid = 1'b1; in_data = d; in_channel = ch; in_sop = sop; in_eop = eop;
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        if (!acc) begin
            tests_run++; tests_failed++;
            $display("FAIL send_timeout: beat %0h never accepted, in_ready=%0b required 1", d, in_ready);
        end
    endtask

    task automatic clear_obs();
        q.delete();
        n_drop = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 0; in_data = 0; in_channel = 0; in_sop = 0; in_eop = 0; out_ready = 1'b1;
        b_in_valid = 0; b_in_data = 0; b_in_channel = 0; b_in_sop = 0; b_in_eop = 0; b_out_ready = 1'b1;
`ifdef AVST_CHADAP_DROP_CNT_EN
        drop_count_clr = 1'b0; b_drop_count_clr = 1'b0;
`endif
        repeat (3) tick();
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        tests_run++; if ({out_data, out_channel, out_sop, out_eop} !== 12'h0) begin tests_failed++;
            $display("FAIL reset_out_fields: got %0h required 0", {out_data, out_channel, out_sop, out_eop}); end
        tests_run++; if (drop_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_drop_pulse: got %0b required 0", drop_pulse); end
        reset_n = 1'b1;
        tick();
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %0b required 1", in_ready); end
        tests_run++; if (b_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready_b: got %0b required 1", b_in_ready); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(8'hA0 + 8'(i), 8'(i), 1'b1, 1'b1);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 8'hA0 + 8'(i) || out_channel !== 2'(i) || out_sop !== 1'b1 || out_eop !== 1'b1 || drop_pulse !== 1'b0) begin
                tests_failed++;
                $display("FAIL stream_beat%0d: got v=%0b d=%0h ch=%0d sop=%0b eop=%0b drop=%0b required v=1 d=%0h ch=%0d sop=1 eop=1 drop=0",
                         i, out_valid, out_data, out_channel, out_sop, out_eop, drop_pulse, 8'hA0 + 8'(i), i);
            end
        end
        idle(2);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_drained: out_valid=%0b required 0", out_valid); end
    endtask

    task automatic test_pkt_drop();
        logic [7:0] exp_d [3];
        logic       exp_s [3];
        logic       exp_e [3];
        exp_d = '{8'h60, 8'h61, 8'h62};
        exp_s = '{1'b1, 1'b0, 1'b0};
        exp_e = '{1'b0, 1'b0, 1'b1};
        clear_obs();
        send(8'h50, 8'd5, 1'b1, 1'b0);
        send(8'h51, 8'd2, 1'b0, 1'b0);
        send(8'h52, 8'd2, 1'b0, 1'b0);
        send(8'h53, 8'd2, 1'b0, 1'b1);
        idle(3);
        tests_run++; if (q.size() != 0) begin tests_failed++; $display("FAIL pkt_drop_outputs: got %0d beats required 0", q.size()); end
        tests_run++; if (n_drop != 4) begin tests_failed++; $display("FAIL pkt_drop_pulses: got %0d required 4", n_drop); end
        clear_obs();
        send(8'h60, 8'd1, 1'b1, 1'b0);
        send(8'h61, 8'd3, 1'b0, 1'b0);  // own channel ignored mid-packet
        send(8'h62, 8'd0, 1'b0, 1'b1);
        idle(3);
        tests_run++;
        if (q.size() != 3 || n_drop != 0) begin
            tests_failed++;
            $display("FAIL pkt_fwd_count: got %0d beats %0d drops required 3 beats 0 drops", q.size(), n_drop);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (q[i] !== {exp_d[i], 2'd1, exp_s[i], exp_e[i]}) begin
                    tests_failed++;
                    $display("FAIL pkt_fwd_beat%0d: got %0h required %0h", i, q[i], {exp_d[i], 2'd1, exp_s[i], exp_e[i]});
                end
            end
        end
    endtask

    task automatic test_sop_restart();
        clear_obs();
        send(8'h70, 8'd1, 1'b1, 1'b0);  // opens a forwarded packet
        send(8'h71, 8'd6, 1'b1, 1'b1);  // new SOP, out of range, single beat
        send(8'h72, 8'd2, 1'b0, 1'b1);  // no SOP while idle
        idle(3);
        tests_run++;
        if (q.size() != 1 || n_drop != 2) begin
            tests_failed++;
            $display("FAIL sop_restart_counts: got %0d beats %0d drops required 1 beat 2 drops", q.size(), n_drop);
        end else begin
            tests_run++;
            if (q[0] !== {8'h70, 2'd1, 1'b1, 1'b0}) begin
                tests_failed++; $display("FAIL sop_restart_beat: got %0h required %0h", q[0], {8'h70, 2'd1, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_rebase();
        logic [7:0] chs [4];
        logic       drp [4];
        logic [1:0] och [4];
        chs = '{8'd3, 8'd4, 8'd7, 8'd8};
        drp = '{1'b1, 1'b0, 1'b0, 1'b1};
        och = '{2'd0, 2'd0, 2'd3, 2'd0};
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (b_in_ready !== 1'b1) begin tests_failed++; $display("FAIL rebase_ready%0d: got %0b required 1", i, b_in_ready); end
            b_in_valid = 1'b1; b_in_data = 8'hC0 + 8'(i); b_in_channel = chs[i]; b_in_sop = 1'b1; b_in_eop = 1'b1;
            tick();
            tests_run++;
            if (b_drop_pulse !== drp[i] || b_out_valid !== !drp[i]) begin
                tests_failed++;
                $display("FAIL rebase_ch%0d: got drop=%0b valid=%0b required drop=%0b valid=%0b", chs[i], b_drop_pulse, b_out_valid, drp[i], !drp[i]);
            end else if (!drp[i]) begin
                tests_run++;
                if (b_out_channel !== och[i] || b_out_data !== 8'hC0 + 8'(i)) begin
                    tests_failed++;
                    $display("FAIL rebase_out%0d: got ch=%0d d=%0h required ch=%0d d=%0h", chs[i], b_out_channel, b_out_data, och[i], 8'hC0 + 8'(i));
                end
            end
        end
        b_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int  k;
        logic acc;
        clear_obs();
        k = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_channel = 8'd0; in_sop = 1'b1; in_eop = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data = 8'h80 + 8'(k);
            @(negedge clk); acc = in_ready;
            tick();
            if (acc) k++;
            if (c >= 1) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== 8'h80) begin
                    tests_failed++; $display("FAIL bp_stable%0d: got v=%0b d=%0h required v=1 d=80", c, out_valid, out_data);
                end
            end
        end
        tests_run++; if (k != 2) begin tests_failed++; $display("FAIL bp_accepts: got %0d required 2", k); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready: got %0b required 0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 50 && k < 6; c++) begin
            in_data = 8'h80 + 8'(k);
            @(negedge clk); acc = in_ready;
            tick();
            if (acc) k++;
        end
        idle(4);
        tests_run++;
        if (q.size() != 6) begin
            tests_failed++; $display("FAIL bp_drain_count: got %0d required 6", q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if (q[i].d !== 8'h80 + 8'(i)) begin
                    tests_failed++; $display("FAIL bp_drain_order%0d: got %0h required %0h", i, q[i].d, 8'h80 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(8'h11, 8'd1, 1'b1, 1'b0);
        send(8'h12, 8'd1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin tests_failed++;
            $display("FAIL rstmid_out: got v=%0b d=%0h required v=0 d=0", out_valid, out_data); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ready: got %0b required 0", in_ready); end
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        clear_obs();
        send(8'h13, 8'd1, 1'b0, 1'b1);
        idle(2);
        tests_run++; if (q.size() != 0 || n_drop != 1) begin tests_failed++;
            $display("FAIL rstmid_nosop: got %0d beats %0d drops required 0 beats 1 drop", q.size(), n_drop); end
        clear_obs();
        send(8'h14, 8'd2, 1'b1, 1'b1);
        idle(2);
        tests_run++;
        if (q.size() != 1) begin
            tests_failed++; $display("FAIL rstmid_newpkt: got %0d beats required 1", q.size());
        end else begin
            tests_run++;
            if (q[0] !== {8'h14, 2'd2, 1'b1, 1'b1}) begin
                tests_failed++; $display("FAIL rstmid_newbeat: got %0h required %0h", q[0], {8'h14, 2'd2, 1'b1, 1'b1});
            end
        end
    endtask

`ifdef AVST_CHADAP_DROP_CNT_EN
    task automatic test_drop_count();
        drop_count_clr = 1'b1;
        idle(1);
        drop_count_clr = 1'b0;
        tests_run++; if (drop_count !== 32'd0) begin tests_failed++; $display("FAIL dcnt_clear: got %0d required 0", drop_count); end
        for (int i = 0; i < 10; i++) send(8'(i), 8'd9, 1'b1, 1'b1);
        idle(1);
        tests_run++; if (drop_count !== 32'd10) begin tests_failed++; $display("FAIL dcnt_ten: got %0d required 10", drop_count); end
        drop_count_clr = 1'b1;
        send(8'hEE, 8'd9, 1'b1, 1'b1);
        drop_count_clr = 1'b0;
        idle(1);
        tests_run++; if (drop_count !== 32'd0) begin tests_failed++; $display("FAIL dcnt_clr_wins: got %0d required 0", drop_count); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_pkt_drop();
        test_sop_restart();
        test_rebase();
        test_backpressure();
        test_reset_mid();
`ifdef AVST_CHADAP_DROP_CNT_EN
        test_drop_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
